nibble_serial_alu_ctrl: RTL and testbench

Multi-cycle sequencer that runs a W-bit add, subtract, AND or OR through a single 4-bit slice, one nibble per clock, LSB nibble first. It registers the carry between nibbles and collects result nibbles in a working register. It presents one start/busy/done handshake to the surrounding datapath or FSM. It lets the lab's 4-bit arithmetic and logic slices serve as wider ALU operands without replicating hardware.

---
 rtl/nibble_serial_alu_ctrl.sv | 84 ++++++++
 tb/tb_nibble_serial_alu_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/nibble_serial_alu_ctrl.sv
// nibble_serial_alu_ctrl: runs a W-bit add/sub/AND/OR through one 4-bit slice, LSB nibble first
module nibble_serial_alu_ctrl #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES,
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         co,
  output logic         ovf,
  output logic         zero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);
  state_t state, nstate;
  logic [W-1:0] a_q, b_q, work, word;
  logic [1:0] op_q;
  logic [IW-1:0] idx;
  logic carry, c_out, sub, arith, accept, last;
  logic [3:0] an, bn, bx, s_arith, s;
  assign sub = op_q == 2'b01;
  assign arith = ~op_q[1];
  assign accept = start && state != RUN;
  assign last = idx == LAST;
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    an = a_q[idx*4 +: 4];
    bn = b_q[idx*4 +: 4];
    bx = bn ^ {4{sub}};
    {c_out, s_arith} = {1'b0, an} + {1'b0, bx} + {4'b0, carry};
    s = arith ? s_arith : op_q[0] ? an | bn : an & bn;
    word = work;
    word[idx*4 +: 4] = s;
  end
  always_comb begin
    nstate = state;
    if (state == RUN) nstate = last ? DONE : RUN;
    else if (accept) nstate = RUN;
    else if (state == DONE) nstate = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      idx <= '0;
      carry <= 1'b0;
      work <= '0;
      result <= '0;
      co <= 1'b0;
      ovf <= 1'b0;
      zero <= 1'b0;
    end else begin
      state <= nstate;
      if (accept) begin
        a_q <= a;
        b_q <= b;
        op_q <= op;
        idx <= '0;
        carry <= op == 2'b01;
      end else if (state == RUN) begin
        work <= word;
        idx <= idx + 1'b1;
        if (arith) carry <= c_out;
        // flags come from the MSB nibble, which is the one processed on the last edge
        if (last) begin
          result <= word;
          co <= arith & (c_out ^ sub);
          ovf <= arith & (an[3] == bx[3]) & (s[3] != an[3]);
          zero <= word == '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// tb_nibble_serial_alu_ctrl: directed and random checks against a word-level ALU model
module tb_nibble_serial_alu_ctrl;
  logic clk = 0, rst = 0, start = 0;
  logic [1:0] op = 0;
  logic [15:0] a = 0, b = 0;
  logic busy, done, co, ovf, zero;
  logic [15:0] result;
  int checks = 0, failures = 0;
  logic [15:0] exp_r, prev_r;
  logic exp_c, exp_v, exp_z;

  nibble_serial_alu_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .co(co), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    logic [16:0] t;
    case (o)
      2'b00: begin t = x + y; exp_r = t[15:0]; exp_c = t[16];
        exp_v = x[15] == y[15] && exp_r[15] != x[15]; end
      2'b01: begin exp_r = x - y; exp_c = x < y;
        exp_v = x[15] != y[15] && exp_r[15] != x[15]; end
      2'b10: begin exp_r = x & y; exp_c = 0; exp_v = 0; end
      default: begin exp_r = x | y; exp_c = 0; exp_v = 0; end
    endcase
    exp_z = exp_r == 0;
  endtask

  task automatic launch(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    start = 1; op = o; a = x; b = y;
    model(o, x, y);
    @(negedge clk);
    start = 0; a = 16'($urandom); b = 16'($urandom);
  endtask

  task automatic expect_run(input bit noise);
    for (int i = 0; i < 4; i++) begin
      check("busy_run", busy, 1);
      check("done_run", done, 0);
      check("result_held", result, prev_r);
      if (noise) begin
        start = 1'($urandom); op = 2'($urandom); a = 16'($urandom); b = 16'($urandom);
      end
      @(negedge clk);
    end
    start = 0;
    check("done_pulse", done, 1);
    check("busy_done", busy, 0);
    check("result", result, exp_r);
    check("co", co, exp_c);
    check("ovf", ovf, exp_v);
    check("zero", zero, exp_z);
    prev_r = exp_r;
  endtask

  task automatic to_idle();
    @(negedge clk);
    check("done_single", done, 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    #1 rst = 1;
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out", {result, co, ovf, zero}, 0);
    prev_r = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    launch(2'b00, 16'h1234, 16'h0FFF); expect_run(0); to_idle();
    launch(2'b01, 16'h0003, 16'h0005); expect_run(0); to_idle();
    launch(2'b01, 16'h8000, 16'h0001); expect_run(0); to_idle();
    launch(2'b00, 16'h7FFF, 16'h0001); expect_run(0); to_idle();
    launch(2'b00, 16'hFFFF, 16'h0001); expect_run(0); to_idle();
    launch(2'b10, 16'hF0F0, 16'h3C3C); expect_run(0);
    launch(2'b11, 16'hF0F0, 16'h3C3C); expect_run(0); to_idle();
    launch(2'b00, 16'h1111, 16'h2222); expect_run(1); to_idle();
    launch(2'b00, 16'h4321, 16'h1234);
    check("busy_c1", busy, 1);
    @(negedge clk);
    #1 rst = 1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_out", {result, co, ovf, zero}, 0);
    prev_r = 0;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      check("no_done_after_rst", done, 0);
      @(negedge clk);
    end
    launch(2'b01, 16'h1000, 16'h0001); expect_run(0); to_idle();
    for (int i = 0; i < 40; i++) begin
      launch(2'($urandom), 16'($urandom), 16'($urandom));
      expect_run($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) to_idle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
